// File: rtl/sram_mux_pkg.sv
// sram_mux_pkg: shared encodings for the slot-wheel SRAM multiplexer
package sram_mux_pkg;
    typedef enum logic {PH_SETUP = 1'b0, PH_DATA = 1'b1} phase_t;
    typedef enum logic [1:0] {OP_IDLE = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2} op_t;
    function automatic int slot_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sram_mux_port.sv
// sram_mux_port: per-port read-data register and one-clock completion pulse
module sram_mux_port
    import sram_mux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hit,
    input  phase_t        phase,
    input  op_t           op,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] dout,
    output logic          ack
);
    logic done;
    assign done = hit && phase == PH_DATA && op != OP_IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            ack  <= 1'b0;
        end else begin
            ack <= done;
            if (done && op == OP_READ) dout <= d;
        end
    end
endmodule

// File: rtl/sram_mux_nport.sv
// sram_mux_nport: shares one async SRAM among NPORTS masters on a fixed 2-clock slot wheel
module sram_mux_nport
    import sram_mux_pkg::*;
#(
    parameter int AW        = 19,
    parameter int DW        = 8,
    parameter int NPORTS    = 3,
    parameter int SKIP_IDLE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NPORTS*AW-1:0] a_bus,
    input  logic [NPORTS*DW-1:0] din_bus,
    output logic [NPORTS*DW-1:0] dout_bus,
    input  logic [NPORTS-1:0]    rd_n_bus,
    input  logic [NPORTS-1:0]    wr_n_bus,
    output logic [NPORTS-1:0]    ack_bus,
    output logic [AW-1:0]        sram_a,
    inout  wire  [DW-1:0]        sram_d,
    output logic                 sram_we_n,
    output logic                 sram_oe_n
);
    localparam int SW = slot_w(NPORTS);
    logic [SW-1:0] slot, slot_nxt;
    phase_t phase, phase_nxt;
    op_t op_q, op_nxt, op_s, op_d;
    logic [AW-1:0] a_cur;
    logic [DW-1:0] din_cur;
    logic rd_cur, wr_cur, drive;
    assign a_cur   = a_bus[int'(slot)*AW +: AW];
    assign din_cur = din_bus[int'(slot)*DW +: DW];
    assign rd_cur  = rd_n_bus[slot];
    assign wr_cur  = wr_n_bus[slot];
    // wr_n is re-checked in DATA so a master can withdraw a write after SETUP
    always_comb begin
        op_s      = (slot == '0) ? OP_READ : !wr_cur ? OP_WRITE : !rd_cur ? OP_READ : OP_IDLE;
        op_d      = (op_q == OP_WRITE && wr_cur) ? OP_IDLE : op_q;
        phase_nxt = (phase == PH_SETUP) ? PH_DATA : PH_SETUP;
        op_nxt    = (phase == PH_SETUP) ? op_s : op_q;
        slot_nxt  = '0;
        for (int k = NPORTS - 1; k > 0; k--)
            if (k > int'(slot) && (SKIP_IDLE == 0 || !rd_n_bus[k] || !wr_n_bus[k])) slot_nxt = SW'(k);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot  <= '0;
            phase <= PH_SETUP;
            op_q  <= OP_IDLE;
        end else begin
            phase <= phase_nxt;
            op_q  <= op_nxt;
            slot  <= (phase == PH_DATA) ? slot_nxt : slot;
        end
    end
    // pins are gated by rst_n so they go quiet the moment reset asserts
    assign drive     = rst_n && phase == PH_DATA && op_d == OP_WRITE;
    assign sram_a    = rst_n ? a_cur : '0;
    assign sram_we_n = !drive;
    assign sram_oe_n = !(rst_n && ((phase == PH_SETUP) ? op_s : op_q) == OP_READ);
    assign sram_d    = drive ? din_cur : 'z;
    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        sram_mux_port #(.DW(DW)) u_port (
            .clk   (clk),
            .rst_n (rst_n),
            .hit   (int'(slot) == i),
            .phase (phase),
            .op    (op_d),
            .d     (sram_d),
            .dout  (dout_bus[i*DW +: DW]),
            .ack   (ack_bus[i])
        );
    end
endmodule

// File: tb/tb_sram_mux_nport.sv
// tb_sram_mux_nport: directed checks of the slot wheel against a behavioural async SRAM
module tb_sram_mux_nport;
    localparam int AW = 19, DW = 8, N = 3;
    localparam logic [AW-1:0] B0 = 19'h00AAA, B1 = 19'h11111, B2 = 19'h22222;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [N*AW-1:0] a_bus, a2_bus;
    logic [N*DW-1:0] din_bus, din2_bus, dout_bus, dout2_bus;
    logic [N-1:0] rd_n_bus, wr_n_bus, ack_bus, rd_n2_bus, wr_n2_bus, ack2_bus;
    logic [AW-1:0] sram_a, sram_a2;
    wire [DW-1:0] sram_d, sram_d2;
    logic sram_we_n, sram_oe_n, sram_we2_n, sram_oe2_n;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int checks = 0, failures = 0, cyc = 0;
    always #5 clk = ~clk;
    assign sram_d  = (!sram_oe_n && sram_we_n) ? mem[sram_a] : 'z;
    assign sram_d2 = (!sram_oe2_n && sram_we2_n) ? 8'hEE : 'z;
    sram_mux_nport #(.AW(AW), .DW(DW), .NPORTS(N), .SKIP_IDLE(0)) dut (
        .clk(clk), .rst_n(rst_n), .a_bus(a_bus), .din_bus(din_bus), .dout_bus(dout_bus),
        .rd_n_bus(rd_n_bus), .wr_n_bus(wr_n_bus), .ack_bus(ack_bus), .sram_a(sram_a),
        .sram_d(sram_d), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n));
    sram_mux_nport #(.AW(AW), .DW(DW), .NPORTS(N), .SKIP_IDLE(1)) dut_skip (
        .clk(clk), .rst_n(rst_n), .a_bus(a2_bus), .din_bus(din2_bus), .dout_bus(dout2_bus),
        .rd_n_bus(rd_n2_bus), .wr_n_bus(wr_n2_bus), .ack_bus(ack2_bus), .sram_a(sram_a2),
        .sram_d(sram_d2), .sram_we_n(sram_we2_n), .sram_oe_n(sram_oe2_n));

    // SRAM write model and cycle counter share the one stimulus process
    task automatic tick();
        @(negedge clk);
        if (!sram_we_n) mem[sram_a] = sram_d;
        cyc++;
    endtask
    task automatic goto(input int p);
        repeat (6) if (cyc % 6 != p) tick();
    endtask
    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        #1;
    endtask

    task automatic test_reset();
        mem[19'h12345] = 8'hA5;
        mem[19'h00020] = 8'h11;
        repeat (5) tick();
        checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL rst_we_n got=%b exp=1", sram_we_n); end
        checks++; if (sram_oe_n !== 1'b1) begin failures++; $display("FAIL rst_oe_n got=%b exp=1", sram_oe_n); end
        checks++; if (sram_a !== '0) begin failures++; $display("FAIL rst_sram_a got=%h exp=0", sram_a); end
        checks++; if (dout_bus !== '0) begin failures++; $display("FAIL rst_dout got=%h exp=0", dout_bus); end
        checks++; if (ack_bus !== '0) begin failures++; $display("FAIL rst_ack got=%b exp=000", ack_bus); end
        release_rst();
        checks++; if (sram_a !== 19'h12345) begin failures++; $display("FAIL setup0_addr got=%h exp=12345", sram_a); end
        checks++; if (sram_oe_n !== 1'b0) begin failures++; $display("FAIL setup0_oe_n got=%b exp=0", sram_oe_n); end
    endtask

    task automatic test_video_read();
        tick();
        checks++; if (sram_oe_n !== 1'b0) begin failures++; $display("FAIL data0_oe_n got=%b exp=0", sram_oe_n); end
        checks++; if (ack_bus !== 3'b000) begin failures++; $display("FAIL data0_ack got=%b exp=000", ack_bus); end
        tick();
        checks++; if (ack_bus !== 3'b001) begin failures++; $display("FAIL video_ack got=%b exp=001", ack_bus); end
        checks++; if (dout_bus[7:0] !== 8'hA5) begin failures++; $display("FAIL video_dout got=%h exp=a5", dout_bus[7:0]); end
        for (int j = 3; j < 15; j++) begin
            tick();
            checks++;
            if (ack_bus[0] !== (cyc % 6 == 2)) begin
                failures++; $display("FAIL video_period cyc=%0d got=%b exp=%b", cyc, ack_bus[0], cyc % 6 == 2);
            end
        end
    endtask

    task automatic test_write();
        int lows = 0;
        goto(0);
        a_bus[2*AW +: AW] = 19'h7FFFF;
        din_bus[2*DW +: DW] = 8'h3C;
        wr_n_bus[2] = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (!sram_we_n) lows++;
            if (j == 5) begin
                checks++; if (sram_we_n !== 1'b0) begin failures++; $display("FAIL wr2_we_n got=%b exp=0", sram_we_n); end
                checks++; if (sram_d !== 8'h3C) begin failures++; $display("FAIL wr2_data got=%h exp=3c", sram_d); end
            end
            tick();
        end
        checks++; if (lows != 1) begin failures++; $display("FAIL wr2_we_width got=%0d exp=1", lows); end
        checks++; if (ack_bus[2] !== 1'b1) begin failures++; $display("FAIL wr2_ack got=%b exp=1", ack_bus[2]); end
        wr_n_bus[2] = 1'b1;
        tick();
        checks++; if (ack_bus[2] !== 1'b0) begin failures++; $display("FAIL wr2_ack_once got=%b exp=0", ack_bus[2]); end
        checks++; if (mem[19'h7FFFF] !== 8'h3C) begin failures++; $display("FAIL wr2_mem got=%h exp=3c", mem[19'h7FFFF]); end
    endtask

    task automatic test_readback();
        goto(0);
        a_bus[AW +: AW] = 19'h7FFFF;
        rd_n_bus[1] = 1'b0;
        goto(4);
        checks++; if (ack_bus[1] !== 1'b1) begin failures++; $display("FAIL rd1_ack got=%b exp=1", ack_bus[1]); end
        checks++; if (dout_bus[DW +: DW] !== 8'h3C) begin failures++; $display("FAIL rd1_dout got=%h exp=3c", dout_bus[DW +: DW]); end
        rd_n_bus[1] = 1'b1;
    endtask

    task automatic test_rw_both();
        goto(0);
        a_bus[AW +: AW] = 19'h00010;
        din_bus[DW +: DW] = 8'h5A;
        rd_n_bus[1] = 1'b0;
        wr_n_bus[1] = 1'b0;
        goto(3);
        checks++; if (sram_we_n !== 1'b0) begin failures++; $display("FAIL rw_we_n got=%b exp=0", sram_we_n); end
        checks++; if (sram_d !== 8'h5A) begin failures++; $display("FAIL rw_data got=%h exp=5a", sram_d); end
        goto(4);
        rd_n_bus[1] = 1'b1;
        wr_n_bus[1] = 1'b1;
        checks++; if (ack_bus[1] !== 1'b1) begin failures++; $display("FAIL rw_ack got=%b exp=1", ack_bus[1]); end
        checks++; if (dout_bus[DW +: DW] !== 8'h3C) begin failures++; $display("FAIL rw_dout got=%h exp=3c", dout_bus[DW +: DW]); end
        checks++; if (mem[19'h00010] !== 8'h5A) begin failures++; $display("FAIL rw_mem got=%h exp=5a", mem[19'h00010]); end
        tick();
        checks++; if (ack_bus[1] !== 1'b0) begin failures++; $display("FAIL rw_ack_once got=%b exp=0", ack_bus[1]); end
    endtask

    task automatic test_cancel();
        goto(0);
        a_bus[AW +: AW] = 19'h00020;
        din_bus[DW +: DW] = 8'h77;
        wr_n_bus[1] = 1'b0;
        goto(2);
        @(posedge clk);
        #1 wr_n_bus[1] = 1'b1;
        tick();
        checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL cancel_we_n got=%b exp=1", sram_we_n); end
        tick();
        checks++; if (ack_bus[1] !== 1'b0) begin failures++; $display("FAIL cancel_ack got=%b exp=0", ack_bus[1]); end
        checks++; if (mem[19'h00020] !== 8'h11) begin failures++; $display("FAIL cancel_mem got=%h exp=11", mem[19'h00020]); end
        checks++; if (dout_bus[DW +: DW] !== 8'h3C) begin failures++; $display("FAIL cancel_dout got=%h exp=3c", dout_bus[DW +: DW]); end
    endtask

    task automatic test_reset_mid_write();
        goto(0);
        a_bus[AW +: AW] = 19'h00030;
        din_bus[DW +: DW] = 8'h99;
        wr_n_bus[1] = 1'b0;
        goto(3);
        checks++; if (sram_we_n !== 1'b0) begin failures++; $display("FAIL midwr_we_n got=%b exp=0", sram_we_n); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (sram_we_n !== 1'b1) begin failures++; $display("FAIL midwr_rst_we_n got=%b exp=1", sram_we_n); end
        checks++; if (sram_oe_n !== 1'b1) begin failures++; $display("FAIL midwr_rst_oe_n got=%b exp=1", sram_oe_n); end
        checks++; if (dout_bus !== '0) begin failures++; $display("FAIL midwr_rst_dout got=%h exp=0", dout_bus); end
        wr_n_bus[1] = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_skip_idle();
        logic [AW-1:0] exp;
        rst_n = 1'b0;
        rd_n2_bus = 3'b101;
        repeat (2) tick();
        release_rst();
        for (int j = 0; j < 8; j++) begin
            exp = (j % 2 == 1) ? B1 : B0;
            checks++; if (sram_a2 !== exp) begin failures++; $display("FAIL skip01_slot j=%0d got=%h exp=%h", j, sram_a2, exp); end
            repeat (2) tick();
        end
        rd_n2_bus = 3'b001;
        for (int j = 0; j < 6; j++) begin
            exp = (j % 3 == 0) ? B0 : (j % 3 == 1) ? B1 : B2;
            checks++; if (sram_a2 !== exp) begin failures++; $display("FAIL skip012_slot j=%0d got=%h exp=%h", j, sram_a2, exp); end
            repeat (2) tick();
        end
    endtask

    initial begin
        a_bus = '0;
        a_bus[AW-1:0] = 19'h12345;
        din_bus = '0;
        rd_n_bus = '1;
        wr_n_bus = '1;
        a2_bus = {B2, B1, B0};
        din2_bus = '0;
        rd_n2_bus = '1;
        wr_n2_bus = '1;
        test_reset();
        test_video_read();
        test_write();
        test_readback();
        test_rw_both();
        test_cancel();
        test_reset_mid_write();
        test_skip_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_mux_nport.md
Name: sram_mux_nport

Overview:
- Successor to the two-port SRAM time-multiplexer.
- Shares one asynchronous 8-bit external SRAM among NPORTS internal masters using a deterministic slot wheel. Each slot is 2 clocks: SETUP, then DATA.
- Port 0 is the video fetch port: read-only, serviced every frame, no handshake.
- Ports 1..NPORTS-1 are CPU/DMA-style masters with read/write strobes and an ack pulse. Sits between the core clock domain and the board SRAM pins.

Parameters:
- AW, 19, address width (512 KB SRAM).
- DW, 8, data width.
- NPORTS, 3, number of ports, 2..8; port 0 is always the video port.
- SKIP_IDLE, 0. When 0, every slot is consumed (fixed frame of 2*NPORTS clocks, contention-exact). When 1, slots of idle ports 1..N-1 are skipped.

Ports:
- clk  in  1  system clock (20 MHz nominal).
- rst_n  in  1  asynchronous active-low reset.
- a_bus  in  NPORTS*AW  per-port address; port i uses bits [i*AW +: AW].
- din_bus  in  NPORTS*DW  per-port write data; the port 0 slice is ignored.
- dout_bus  out  NPORTS*DW  per-port registered read data.
- rd_n_bus  in  NPORTS  per-port read request, active low; bit 0 is ignored (port 0 always reads).
- wr_n_bus  in  NPORTS  per-port write request, active low; bit 0 is ignored.
- ack_bus  out  NPORTS  one-clock completion pulse per port; bit 0 pulses on each video fetch.
- sram_a  out  AW  SRAM address.
- sram_d  inout  DW  SRAM data.
- sram_we_n  out  1  SRAM write enable, active low.
- sram_oe_n  out  1  SRAM output enable, active low.

Behaviour:
- Reset values (asynchronous):
  - slot=0, phase=SETUP.
  - sram_we_n=1, sram_oe_n=1, sram_d=Z, sram_a=0.
  - dout_bus=0, ack_bus=0.
  - sram_we_n must go high in the same cycle rst_n falls, even mid-write.
- Phases: SETUP then DATA, 1 clk each. The slot counter advances after DATA.
  - SKIP_IDLE=0: slot wraps NPORTS-1 -> 0.
  - SKIP_IDLE=1: the next slot is the lowest-numbered active port above the current slot. A port is active if it is port 0 or has rd_n or wr_n low. If no such port exists, the next slot is 0.
- SETUP:
  - sram_a = a of current slot.
  - The operation is sampled here: write if wr_n=0, else read if rd_n=0, else idle. Port 0 is always read.
  - Simultaneous rd_n=0 and wr_n=0: the write wins.
  - sram_we_n=1. sram_oe_n=0 for a read, else 1.
- DATA, read:
  - sram_a held, sram_oe_n=0.
  - dout slice of the slot port <= sram_d at the end of DATA.
  - ack bit pulses high for the clock following DATA.
- DATA, write:
  - Requires wr_n still 0; this is re-checked in DATA.
  - sram_a held, sram_d driven with din, sram_we_n=0 for exactly this clock, sram_oe_n=1.
  - ack pulses the clock after DATA.
  - If wr_n has risen since SETUP, the write is cancelled: we_n stays 1, d stays Z, no ack.
- DATA, idle slot: bus quiet (oe_n=1, we_n=1, d=Z), no ack, dout unchanged.
- sram_d is driven only in a write DATA phase. It is Z in every SETUP, which gives one turnaround clock.
- dout slices hold their last value indefinitely; there is no tristating on the internal side.
- Latency:
  - A request asserted before the SETUP of its slot completes with ack 2 clocks after SETUP begins.
  - Worst-case wait is 2*NPORTS clocks.
  - The master must hold a, din and strobes until ack.
  - Holding a strobe past ack re-issues the operation on the next visit to that slot.
- Address and data pass unmodified; no arithmetic on addresses.

Decomposition:
- Package sram_mux_pkg:
  - phase encoding (PH_SETUP=0, PH_DATA=1);
  - op encoding (OP_IDLE, OP_READ, OP_WRITE);
  - a function for slot counter width, clog2(NPORTS), minimum 1.
- Sub-module sram_mux_port: per-port output register and ack generator. Instantiated NPORTS times via generate; inputs are slot-hit, phase, op and sram_d.
- The top level holds the slot wheel, the op latch and the pin drivers.

Test Plan (NPORTS=3, AW=19, DW=8, behavioural async SRAM model):
1. Hold rst_n=0 for 5 clk, then release -> during reset sram_we_n=1, sram_oe_n=1, sram_d=Z, dout_bus=0, ack_bus=0. First SETUP after release shows sram_a=a0. ack_bus[0] pulses at clk 2, then every 6 clks.
2. Preload mem[0x12345]=0xA5, a0=0x12345 -> dout0=0xA5 after the first port-0 DATA. sram_oe_n is low in SETUP and DATA of slot 0.
3. Port 2: a=0x7FFFF, din=0x3C, wr_n=0 -> sram_we_n low exactly 1 clk, in slot-2 DATA, with sram_d=0x3C. ack2 pulses once. A later port-1 read of 0x7FFFF returns dout1=0x3C.
4. Port 1: wr_n=0 at SETUP, raised before DATA -> no we_n pulse, sram_d stays Z, ack1 stays 0, mem unchanged. Separately, rst_n falls mid-write DATA -> sram_we_n=1 immediately.
5. Port 1: rd_n=0 and wr_n=0 together, din=0x5A, a=0x00010 -> write performed (mem=0x5A), dout1 unchanged, ack1 one pulse.
6. SKIP_IDLE=1, only port 1 requesting -> slot sequence 0,1,0,1 with a period of 4 clks. Slot 2 is never visited until rd_n_bus[2]=0, after which the sequence becomes 0,1,2.
